// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the Moore sequence detector stimulus source.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  localparam int DEFAULT_LEN = 20;
  localparam int DEFAULT_DIV = 1;

  // Index width for a LEN-bit pattern, never narrower than one bit.
  function automatic int idxw_of(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Divider that marks the last clock of each bit period; tc is constant 1 when DIV = 1.
module bit_period_counter #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/moore_seq_source.sv
// Shifts a loaded LEN-bit pattern out on x, one bit per DIV clocks, with start/done handshaking.
module moore_seq_source
  import moore_seq_pkg::*;
#(
  parameter  int LEN       = DEFAULT_LEN,
  parameter  int DIV       = DEFAULT_DIV,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int IDXW      = idxw_of(LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [LEN-1:0]  pattern,
  input  logic            start,
  input  logic            rpt,
  output logic            x,
  output logic            x_valid,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] bit_idx,
  output seq_state_t      state
);

  // Handshake: load/start are single-cycle requests honoured only while state is
  // ST_IDLE; anything presented in ST_SHIFT or ST_DONE is dropped, not queued.

  // The register holds the pattern already in shift order, so bit k is the k-th bit sent.
  logic [LEN-1:0] preg;
  logic [LEN-1:0] new_ord;
  logic           tc;
  logic           last_bit;

  always_comb begin
    new_ord = pattern;
    if (MSB_FIRST) new_ord = {<<{pattern}};
  end

  assign last_bit = (bit_idx == IDXW'(LEN - 1));

  bit_period_counter #(.DIV(DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_SHIFT),
    .en  (state == ST_SHIFT),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      preg    <= '0;
      bit_idx <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done    <= 1'b0;
          bit_idx <= '0;
          if (load) preg <= new_ord;
          if (start) begin
            state   <= ST_SHIFT;
            // A same-cycle load must supply the first bit directly.
            x       <= load ? new_ord[0] : preg[0];
            x_valid <= 1'b1;
            busy    <= 1'b1;
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (tc) begin
            if (!last_bit) begin
              bit_idx <= bit_idx + 1'b1;
              x       <= preg[bit_idx + 1'b1];
            end else if (rpt) begin
              bit_idx <= '0;
              x       <= preg[0];
            end else begin
              state   <= ST_DONE;
              bit_idx <= '0;
              x       <= 1'b0;
              x_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seq_source.sv
// Directed bench for moore_seq_source: one DIV=1/MSB-first instance and one DIV=4/LSB-first instance.
module tb_moore_seq_source;
  import moore_seq_pkg::*;

  localparam int LEN  = 20;
  localparam int IDXW = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_load = 0, a_start = 0, a_rpt = 0;
  logic [LEN-1:0]  a_pattern = '0;
  logic            a_x, a_x_valid, a_busy, a_done;
  logic [IDXW-1:0] a_bit_idx;
  seq_state_t      a_state;

  logic            b_load = 0, b_start = 0, b_rpt = 0;
  logic [LEN-1:0]  b_pattern = '0;
  logic            b_x, b_x_valid, b_busy, b_done;
  logic [IDXW-1:0] b_bit_idx;
  seq_state_t      b_state;

  moore_seq_source #(.LEN(LEN), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load(a_load), .pattern(a_pattern), .start(a_start),
    .rpt(a_rpt), .x(a_x), .x_valid(a_x_valid), .busy(a_busy), .done(a_done),
    .bit_idx(a_bit_idx), .state(a_state)
  );

  moore_seq_source #(.LEN(LEN), .DIV(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load(b_load), .pattern(b_pattern), .start(b_start),
    .rpt(b_rpt), .x(b_x), .x_valid(b_x_valid), .busy(b_busy), .done(b_done),
    .bit_idx(b_bit_idx), .state(b_state)
  );

  // Observed-signal mux so one run task serves both instances.
  logic            sel = 1'b0;
  logic            obs_x, obs_valid, obs_busy, obs_done;
  logic [IDXW-1:0] obs_idx;
  assign obs_x     = sel ? b_x       : a_x;
  assign obs_valid = sel ? b_x_valid : a_x_valid;
  assign obs_busy  = sel ? b_busy    : a_busy;
  assign obs_done  = sel ? b_done    : a_done;
  assign obs_idx   = sel ? b_bit_idx : a_bit_idx;

  // Scoreboard
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit seq2[LEN] = '{1,0,0,0,0,1,1,1,0,1,1,0,0,1,1,1,1,0,1,1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks; all driving and sampling happen on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_seq2();
    for (int i = 0; i < LEN; i++) exp_q.push_back(seq2[i]);
  endtask

  task automatic push_const(input int n, input logic v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic load_a(input logic [LEN-1:0] pat);
    a_load = 1'b1; a_pattern = pat;
    step();
    a_load = 1'b0;
  endtask

  task automatic start_a(input logic ld, input logic [LEN-1:0] pat, input logic rp);
    a_load = ld; a_pattern = pat; a_start = 1'b1; a_rpt = rp;
    step();
    a_load = 1'b0; a_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"},     obs_x,     0);
    check({tag, "_valid"}, obs_valid, 0);
    check({tag, "_busy"},  obs_busy,  0);
    check({tag, "_done"},  obs_done,  0);
    check({tag, "_idx"},   obs_idx,   0);
  endtask

  // Follows one run from its first valid cycle; -1 disables drop/inject/reset actions.
  task automatic run(input string tag, input int div, input int nvalid_exp,
                     input int drop_at, input int inject_at, input int rst_at);
    int n = 0;
    logic [31:0] e;
    while (obs_valid && n < 400) begin
      e = (exp_q.size() == 0) ? 32'd2 : 32'(exp_q.pop_front());
      check({tag, "_x"}, obs_x, e);
      check({tag, "_idx"}, obs_idx, (n / div) % LEN);
      check({tag, "_busy"}, obs_busy, 1);
      check({tag, "_nodone"}, obs_done, 0);
      if (n == drop_at) a_rpt = 1'b0;
      if (n == inject_at) begin
        a_load = 1'b1; a_pattern = '1; a_start = 1'b1;
      end else begin
        a_load = 1'b0; a_start = 1'b0;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle({tag, "_rst"});
        exp_q.delete();
        return;
      end
      n++;
      step();
    end
    check({tag, "_len"}, n, nvalid_exp);
    check({tag, "_done"}, obs_done, 1);
    check({tag, "_done_x"}, obs_x, 0);
    step();
    check({tag, "_after_done"}, obs_done, 0);
    check({tag, "_after_busy"}, obs_busy, 0);
    exp_q.delete();
  endtask

  initial begin
    // 1: reset state, then a run of the cleared pattern
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_idle("reset_a");
    sel = 1'b1;
    check_idle("reset_b");
    sel = 1'b0;
    start_a(1'b0, '0, 1'b0);
    push_const(LEN, 1'b0);
    run("unloaded", 1, LEN, -1, -1, -1);

    // 2: basic MSB-first run
    load_a(20'b1000_0111_0110_0111_1011);
    check_idle("after_load");
    start_a(1'b0, '0, 1'b0);
    push_seq2();
    run("basic", 1, LEN, -1, -1, -1);

    // 3: divided bit period, LSB first
    sel = 1'b1;
    b_load = 1'b1; b_pattern = 20'h00005; b_start = 1'b1;
    step();
    b_load = 1'b0; b_start = 1'b0;
    for (int i = 0; i < 80; i++) exp_q.push_back((i < 4) || (i >= 8 && i < 12));
    run("div4", 4, 80, -1, -1, -1);
    sel = 1'b0;

    // 4: repeat for two passes, drop rpt during pass 3
    start_a(1'b0, '0, 1'b1);
    push_seq2(); push_seq2(); push_seq2();
    run("repeat", 1, 3 * LEN, 45, -1, -1);

    // 5: ignored load/start mid-run, then reset mid-run and a zero run after it
    start_a(1'b0, '0, 1'b0);
    push_seq2();
    run("ignored", 1, LEN, -1, 3, -1);
    start_a(1'b0, '0, 1'b0);
    push_seq2();
    run("midrst", 1, LEN, -1, -1, 7);
    start_a(1'b0, '0, 1'b0);
    push_const(LEN, 1'b0);
    run("cleared", 1, LEN, -1, -1, -1);

    // 6: same-cycle load and start
    start_a(1'b1, 20'h80000, 1'b0);
    exp_q.push_back(1'b1);
    push_const(LEN - 1, 1'b0);
    run("ldstart", 1, LEN, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
